// File: rtl/tuple_coupler.sv
// -----------------------------------------------------------------------------
// tuple_coupler
//
// Width-doubling stage that sits directly below a 2-wide merger. Consecutive
// 2-element tuples are packed into one 4-element tuple and buffered in a
// first-word-fall-through FIFO that feeds a 4-wide merger input.
//
// A run terminator is an input tuple whose head element (bits [W-1:0]) is
// zero. Terminators are re-encoded so that every output run ends with an
// all-zero 4-tuple. A half-filled tuple left over at the end of a run is
// flushed with zero padding in its upper half.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_data     2W  input tuple, head element in [W-1:0]
//   i_write    1   i_data is valid this cycle
//   o_ready    1   high while free FIFO entries > SKID
//   o_data     4W  FIFO head (first-word-fall-through)
//   o_empty    1   FIFO is empty; o_data is meaningless while set
//   i_read     1   pop the head; ignored while o_empty is set
//   o_count    log2(DEPTH)+1  FIFO occupancy
//   o_overrun  1   sticky: a write was dropped for lack of space
//
// Parameters
//   W      element width
//   DEPTH  FIFO entries; power of two and >= SKID+2
//   SKID   free-entry reserve that absorbs writes still in flight after
//          o_ready falls
//
// Handshake semantics:
//   Input side is credit-style, not valid/ready: upstream registers o_ready
//   and may keep issuing i_write for up to SKID cycles after it drops. A write
//   is taken whenever i_write is high and the entries it produces fit in the
//   free space counted before any same-cycle pop; otherwise the whole write
//   is discarded and o_overrun latches. Output side: a pop happens on
//   i_read && !o_empty, and o_data holds the head until that pop.
// -----------------------------------------------------------------------------
module tuple_coupler #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int SKID  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [2*W-1:0]           i_data,
  input  logic                     i_write,
  output logic                     o_ready,
  output logic [4*W-1:0]           o_data,
  output logic                     o_empty,
  input  logic                     i_read,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SKID_C  = CW'(SKID);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 pending_valid_q, pending_valid_d;
  logic [2*W-1:0]       pending_q,       pending_d;
  logic [AW-1:0]        wr_ptr_q,        wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,        rd_ptr_d;
  logic [CW-1:0]        count_q,         count_d;
  logic                 overrun_q,       overrun_d;

  // Memory has no reset: pointers and count define which entries are live.
  logic [4*W-1:0]       mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic                 is_term;
  logic [1:0]           need;
  logic [CW-1:0]        free;
  logic                 fits;
  logic                 accept;
  logic [1:0]           n_wr;
  logic [4*W-1:0]       wr0_data;
  logic [AW-1:0]        wr_ptr_nxt;
  logic                 pop;

  always_comb begin
    is_term  = (i_data[W-1:0] == '0);
    need     = 2'd0;
    wr0_data = '0;

    if (i_write) begin
      if (is_term) begin
        // Terminator: flush any half tuple (zero padded), then the all-zero
        // end-of-run marker.
        need = pending_valid_q ? 2'd2 : 2'd1;
      end else begin
        // Data: only the second half of a pair produces an entry.
        need = pending_valid_q ? 2'd1 : 2'd0;
      end
    end

    // First entry written this cycle. The second entry, when present, is
    // always the all-zero terminator.
    if (is_term) begin
      wr0_data = pending_valid_q ? {{(2*W){1'b0}}, pending_q} : '0;
    end else begin
      wr0_data = {i_data, pending_q};
    end

    // Free space is taken before any pop in the same cycle, so a read never
    // makes room for a simultaneous write.
    free   = DEPTH_C - count_q;
    fits   = (CW'(need) <= free);
    accept = i_write && fits;
    n_wr   = accept ? need : 2'd0;
    pop    = i_read && (count_q != '0);

    wr_ptr_nxt = wr_ptr_q + AW'(1);
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_d       = pending_q;
    overrun_d       = overrun_q;

    if (accept) begin
      if (is_term) begin
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        pending_valid_d = 1'b0;
      end else begin
        pending_valid_d = 1'b1;
        pending_d       = i_data;
      end
    end

    // A dropped write leaves pending untouched; only the flag records it.
    if (i_write && !fits) begin
      overrun_d = 1'b1;
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + AW'(n_wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_wr) - CW'(pop);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_valid_q <= 1'b0;
      pending_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_q       <= pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overrun_q       <= overrun_d;
    end
  end

  // Dual-entry write port: entry 0 at wr_ptr, terminator at wr_ptr+1.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (n_wr != 2'd0) begin
        mem_q[wr_ptr_q] <= wr0_data;
      end
      if (n_wr == 2'd2) begin
        mem_q[wr_ptr_nxt] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: status depends on registered state only.
  // ---------------------------------------------------------------------------
  assign o_data    = mem_q[rd_ptr_q];
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_ready   = ((DEPTH_C - count_q) > SKID_C);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_tuple_coupler.sv
module tb_tuple_coupler;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int SKID  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  data;
  logic         wr;
  logic         rd;
  logic         ready;
  logic [127:0] odata;
  logic         empty;
  logic [4:0]   count;
  logic         overrun;

  always #5 clk = ~clk;

  tuple_coupler #(.W(W), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_write   (wr),
    .o_ready   (ready),
    .o_data    (odata),
    .o_empty   (empty),
    .i_read    (rd),
    .o_count   (count),
    .o_overrun (overrun)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic e, input logic [4:0] c,
                              input logic r, input logic ov);
    check({tag, " empty"},   128'(empty),   128'(e));
    check({tag, " count"},   128'(count),   128'(c));
    check({tag, " ready"},   128'(ready),   128'(r));
    check({tag, " overrun"}, 128'(overrun), 128'(ov));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: hold inputs for one clock, then sample #1 after the edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic w, input logic [63:0] d, input logic rdv);
    rst  = r;
    wr   = w;
    data = d;
    rd   = rdv;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    data = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst;
    logic         wr;
    logic [63:0]  data;
    logic         rd;
    logic         exp_empty;
    logic [4:0]   exp_count;
    logic         exp_ready;
    logic         exp_ovr;
    logic         chk_data;
    logic [127:0] exp_data;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [63:0] a, b, p, c;

  initial begin
    // pairing
    vecs[0]  = '{1'b0, 1'b1, 64'h00000003_00000005, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    vecs[1]  = '{1'b0, 1'b1, 64'h00000001_00000002, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1,
                 128'h00000001_00000002_00000003_00000005};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    // odd run: half tuple flushed with padding, then zero marker, same edge
    vecs[3]  = '{1'b0, 1'b1, 64'h00000000_00000009, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    vecs[4]  = '{1'b0, 1'b1, 64'h0,                 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1,
                 128'h0000000000000000_0000000000000009};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 128'h0};
    vecs[6]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    // even run
    vecs[7]  = '{1'b0, 1'b1, 64'h00000007_00000008, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    vecs[8]  = '{1'b0, 1'b1, 64'h00000005_00000006, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1,
                 128'h00000005_00000006_00000007_00000008};
    vecs[9]  = '{1'b0, 1'b1, 64'h0,                 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1,
                 128'h00000005_00000006_00000007_00000008};
    vecs[10] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 128'h0};
    vecs[11] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    // terminator with non-zero upper element, nothing pending
    vecs[12] = '{1'b0, 1'b1, 64'hDEADBEEF_00000000, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 128'h0};
    // pop together with a half-tuple write
    vecs[13] = '{1'b0, 1'b1, 64'h00000011_00000022, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};
    // read while empty is ignored; completing write lands
    vecs[14] = '{1'b0, 1'b1, 64'h00000033_00000044, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1,
                 128'h00000033_00000044_00000011_00000022};
    vecs[15] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 128'h0};

    rst  = 1'b1;
    wr   = 1'b0;
    rd   = 1'b0;
    data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_status("reset", 1'b1, 5'd0, 1'b1, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rd);
      check_status($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_count,
                   vecs[i].exp_ready, vecs[i].exp_ovr);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d data", i), odata, vecs[i].exp_data);
    end

    // -------------------------------------------------------------------------
    // Backpressure: fill with pairs, no reads. Ready is high while free > 4.
    // -------------------------------------------------------------------------
    for (int k = 0; k < DEPTH; k++) begin
      a = {32'h100 + k, 32'h200 + k};
      b = {32'h300 + k, 32'h400 + k};
      drive(1'b0, 1'b1, a, 1'b0);
      check($sformatf("fill%0d half count", k), 128'(count), 128'(k));
      drive(1'b0, 1'b1, b, 1'b0);
      exp_q.push_back({b, a});
      check_status($sformatf("fill%0d", k), 1'b0, 5'(k + 1), (k + 1) < 12, 1'b0);
    end
    check("full head", odata, exp_q[0]);

    // Half tuple needs no space: accepted even when full.
    p = 64'hAAAA0001_BBBB0001;
    drive(1'b0, 1'b1, p, 1'b0);
    check_status("full half", 1'b0, 5'd16, 1'b0, 1'b0);

    // Completing write at full is dropped.
    drive(1'b0, 1'b1, 64'h000000C1_000000C2, 1'b0);
    check_status("full drop", 1'b0, 5'd16, 1'b0, 1'b1);

    // Pop and completing write together: pop does not make room.
    check("simul head", odata, exp_q[0]);
    drive(1'b0, 1'b1, 64'h000000C5_000000C6, 1'b1);
    void'(exp_q.pop_front());
    check_status("simul", 1'b0, 5'd15, 1'b0, 1'b1);

    // Terminator with pending needs two entries, only one free: dropped.
    drive(1'b0, 1'b1, 64'h0000FFFF_00000000, 1'b0);
    check_status("term drop", 1'b0, 5'd15, 1'b0, 1'b1);

    // Pending survived both drops and pairs with the next tuple.
    c = 64'h000000C3_000000C4;
    drive(1'b0, 1'b1, c, 1'b0);
    exp_q.push_back({c, p});
    check_status("refill", 1'b0, 5'd16, 1'b0, 1'b1);

    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("drain%0d data", k), odata, exp_q.pop_front());
      drive(1'b0, 1'b0, 64'h0, 1'b1);
    end
    check_status("drained", 1'b1, 5'd0, 1'b1, 1'b1);

    // -------------------------------------------------------------------------
    // Reset mid-run discards pending and clears overrun.
    // -------------------------------------------------------------------------
    drive(1'b0, 1'b1, 64'h0000000A_0000000B, 1'b0);
    check_status("pre-rst", 1'b1, 5'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    check_status("rst", 1'b1, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 64'h00000003_00000004, 1'b0);
    check_status("post-rst half", 1'b1, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 64'h00000001_00000002, 1'b0);
    check_status("post-rst pair", 1'b0, 5'd1, 1'b1, 1'b0);
    check("post-rst data", odata, 128'h00000001_00000002_00000003_00000004);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    check_status("post-rst pop", 1'b1, 5'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
